// File: rtl/da_pkg.sv
// da_pkg: shared state type and sizing helpers for the DA FIR frame controller
package da_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} da_frame_state_t;
  localparam int DA_WORD_WIDTH = 16;
  localparam int DA_CNT_W = $clog2(DA_WORD_WIDTH);
  function automatic int da_out_w(input int word_width, input int num_sub);
    return word_width + $clog2(num_sub);
  endfunction
  function automatic int da_cnt_w(input int word_width);
    return word_width > 1 ? $clog2(word_width) : 1;
  endfunction
endpackage

// File: rtl/da_result_fifo.sv
// da_result_fifo: synchronous first-word-fall-through FIFO with async active-low reset
module da_result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = empty ? '0 : mem_q[rd_q];
  // next pointers and occupancy; a pop frees the slot a same-cycle push may use
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and count registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage, not reset: dout is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/da_frame_ctrl.sv
// da_frame_ctrl: DA FIR sample sequencer and result collector; define DA_FRAME_SAT_EN for saturation and sat_seen
module da_frame_ctrl
  import da_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int NUM_SUB = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int OUT_W = da_out_w(WORD_WIDTH, NUM_SUB)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WORD_WIDTH-1:0]         in_data,
  output logic                          sf_x_we,
  output logic [WORD_WIDTH-1:0]         sf_x,
  output logic                          sf_en,
  output logic                          sf_ts,
  input  logic [NUM_SUB*WORD_WIDTH-1:0] sf_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OUT_W-1:0]              out_data,
  output logic                          busy
`ifdef DA_FRAME_SAT_EN
  ,
  output logic                          sat_seen
`endif
);
  localparam int CW = da_cnt_w(WORD_WIDTH);
  da_frame_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] sf_x_q, sf_x_d;
  logic sf_x_we_q, sf_x_we_d, sf_en_q, sf_en_d, sf_ts_q, sf_ts_d, busy_q, busy_d;
  logic push, last, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] count_unused;
  logic signed [OUT_W-1:0] sum, res;
  assign last      = cnt_q == CW'(WORD_WIDTH-1);
  assign in_ready  = (state_q == IDLE) && !fifo_full;
  assign sf_x_we   = sf_x_we_q;
  assign sf_x      = sf_x_q;
  assign sf_en     = sf_en_q;
  assign sf_ts     = sf_ts_q;
  assign busy      = busy_q;
  assign out_valid = !fifo_empty;
  // next-state logic; strobes are computed one cycle ahead so they leave as flops
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sf_x_d    = sf_x_q;
    sf_x_we_d = 1'b0;
    sf_en_d   = 1'b0;
    sf_ts_d   = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        sf_x_d    = in_data;
        sf_x_we_d = 1'b1;
        state_d   = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = '0;
        sf_en_d = 1'b1;
        sf_ts_d = WORD_WIDTH == 1;
      end
      SHIFT: begin
        cnt_d   = cnt_q + 1'b1;
        push    = last;
        state_d = last ? IDLE : SHIFT;
        sf_en_d = !last;
        sf_ts_d = !last && cnt_q == CW'(WORD_WIDTH-2);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // sign-extend each subfilter output to OUT_W and add; OUT_W leaves room for every carry
  always_comb begin
    sum = '0;
    for (int k = 0; k < NUM_SUB; k++)
      sum = sum + OUT_W'($signed(sf_y[k*WORD_WIDTH +: WORD_WIDTH]));
  end
`ifdef DA_FRAME_SAT_EN
  localparam int MAXV = 2**(WORD_WIDTH-1) - 1;
  logic sat_hi, sat_lo, sat_seen_q, sat_seen_d;
  // clamp to the signed WORD_WIDTH range and remember that it happened
  always_comb begin
    sat_hi     = sum > MAXV;
    sat_lo     = sum < -MAXV - 1;
    res        = sat_hi ? OUT_W'(MAXV) : sat_lo ? OUT_W'(-MAXV - 1) : sum;
    sat_seen_d = sat_seen_q || (push && (sat_hi || sat_lo));
  end
  // sticky saturation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sat_seen_q <= 1'b0;
    else sat_seen_q <= sat_seen_d;
  end
  assign sat_seen = sat_seen_q;
`else
  assign res = sum;
`endif
  // FSM and registered chain strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sf_x_q    <= '0;
      sf_x_we_q <= 1'b0;
      sf_en_q   <= 1'b0;
      sf_ts_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sf_x_q    <= sf_x_d;
      sf_x_we_q <= sf_x_we_d;
      sf_en_q   <= sf_en_d;
      sf_ts_q   <= sf_ts_d;
      busy_q    <= busy_d;
    end
  end
  da_result_fifo #(.WIDTH(OUT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (out_ready),
    .din   (res),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_unused)
  );
endmodule

// File: tb/tb_da_frame_ctrl.sv
// tb_da_frame_ctrl: directed self-checking bench for da_frame_ctrl
module tb_da_frame_ctrl;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic [31:0] sf_y = 0;
  logic in_ready, sf_x_we, sf_en, sf_ts, out_valid, busy;
  logic [15:0] sf_x;
  logic [16:0] out_data;
  int errors = 0, checks = 0;
`ifdef DA_FRAME_SAT_EN
  logic sat_seen;
  localparam logic [31:0] E_POS = 32'h07FFF, E_NEG = 32'h18000;
`else
  localparam logic [31:0] E_POS = 32'h0FFFE, E_NEG = 32'h10000;
`endif
  logic [31:0] exp_q [$];
  logic [31:0] head;
  always #5 clk = ~clk;
  da_frame_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sf_x_we(sf_x_we), .sf_x(sf_x), .sf_en(sf_en), .sf_ts(sf_ts), .sf_y(sf_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef DA_FRAME_SAT_EN
    , .sat_seen(sat_seen)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [15:0] x, input logic [31:0] y, input bit pop, input logic [31:0] hd);
    int n = 0;
    in_data = x;
    in_valid = 1;
    do begin tick(); n++; end while (!sf_x_we && n < 100);
    check("load_we", sf_x_we, 1);
    check("load_x", sf_x, x);
    check("load_en", sf_en, 0);
    check("load_rdy", in_ready, 0);
    check("load_busy", busy, 1);
    in_valid = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("sh_en", sf_en, 1);
      check("sh_ts", sf_ts, i == 15);
      check("sh_we", sf_x_we, 0);
      check("sh_rdy", in_ready, 0);
      if (i == 15) begin
        sf_y = y;
        if (pop) begin
          check("pp_head", out_data, hd);
          out_ready = 1;
        end
      end
    end
    tick();
    sf_y = 0;
    out_ready = 0;
    check("done_en", sf_en, 0);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 1);
  endtask
  task automatic pop_one(input logic [31:0] e);
    check("pop_valid", out_valid, 1);
    check("pop_data", out_data, e);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (10) tick();
    check("rst_rdy", in_ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_en", sf_en, 0);
    check("rst_ts", sf_ts, 0);
    check("rst_we", sf_x_we, 0);
    check("rst_busy", busy, 0);
    check("rst_x", sf_x, 0);
    check("rst_data", out_data, 0);
`ifdef DA_FRAME_SAT_EN
    check("rst_sat", sat_seen, 0);
`endif
    frame(16'h1234, {16'h0100, 16'hFF00}, 0, 0);
    check("basic", out_data, 0);
    pop_one(0);
    check("empty1", out_valid, 0);
    frame(16'h0001, {16'h7FFF, 16'h7FFF}, 0, 0);
    pop_one(E_POS);
`ifdef DA_FRAME_SAT_EN
    check("sat_seen", sat_seen, 1);
`endif
    frame(16'h0002, {16'h8000, 16'h8000}, 0, 0);
    pop_one(E_NEG);
    frame(16'h0011, {16'h0001, 16'h0002}, 0, 0); exp_q.push_back(32'h00003);
    frame(16'h0022, {16'h0010, 16'hFFFF}, 0, 0); exp_q.push_back(32'h0000F);
    frame(16'h0033, {16'hFFFF, 16'hFFFF}, 0, 0); exp_q.push_back(32'h1FFFE);
    frame(16'h0044, {16'h1000, 16'h2000}, 0, 0); exp_q.push_back(32'h03000);
    in_data = 16'h0055;
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_rdy", in_ready, 0);
      check("full_we", sf_x_we, 0);
    end
    head = exp_q.pop_front();
    pop_one(head);
    check("free_rdy", in_ready, 1);
    frame(16'h0055, {16'h8000, 16'h0001}, 0, 0); exp_q.push_back(32'h18001);
    while (exp_q.size() > 0) begin
      head = exp_q.pop_front();
      pop_one(head);
    end
    check("drained", out_valid, 0);
    frame(16'h0066, {16'h0000, 16'h0009}, 0, 0);
    frame(16'h0077, {16'h0100, 16'h0001}, 1, 32'h00009);
    check("pp_new", out_data, 32'h00101);
    pop_one(32'h00101);
    check("pp_empty", out_valid, 0);
    in_data = 16'h5555;
    in_valid = 1;
    tick();
    in_valid = 0;
    check("mr_we", sf_x_we, 1);
    repeat (8) tick();
    check("mr_en", sf_en, 1);
    #2 rst = 0;
    #1;
    check("mr_en0", sf_en, 0);
    check("mr_ts0", sf_ts, 0);
    check("mr_we0", sf_x_we, 0);
    check("mr_x0", sf_x, 0);
    check("mr_busy0", busy, 0);
    check("mr_valid0", out_valid, 0);
    check("mr_data0", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (25) tick();
    check("mr_novalid", out_valid, 0);
    check("mr_idle", busy, 0);
    frame(16'h0088, {16'h0005, 16'h0007}, 0, 0);
    pop_one(32'h0000C);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
